// File: rtl/inout_face_manager_multi_pkg.sv
// Shared constants and types for the multi-channel photodiode face front end.
// Optional width counters are enabled by defining INOUT_FACE_WIDTH_COUNTER_EN.
package inout_face_manager_multi_pkg;

  localparam int DEF_CHANNELS      = 3;
  localparam int MIN_SYNC_STAGES   = 2;
  localparam int DEF_GLITCH_CYCLES = 4;
  localparam int DEF_WIDTH_W       = 16;

  // Filter counter must hold 0..GLITCH_CYCLES-1; never narrower than one bit.
  function automatic int filt_cnt_w(input int glitch_cycles);
    return (glitch_cycles < 1) ? 1 : $clog2(glitch_cycles + 1);
  endfunction

  localparam int DEF_FILT_CNT_W = filt_cnt_w(DEF_GLITCH_CYCLES);

  typedef struct packed {
    logic e_in;
    logic e_rise;
    logic e_fall;
  } env_status_t;

endpackage

// File: rtl/inout_face_manager_multi_channel.sv
// One sensor channel: both-edge data sampler, envelope sync + glitch filter,
// edge strobes and (with INOUT_FACE_WIDTH_COUNTER_EN) an envelope pulse-width counter.
module inout_face_channel
  import inout_face_manager_multi_pkg::*;
#(
  parameter int SYNC_STAGES   = MIN_SYNC_STAGES,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int WIDTH_W       = DEF_WIDTH_W
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               data_i,
  input  logic               env_i,
  input  logic               en_i,
  output logic [1:0]         pair_o,
  output env_status_t        status_o,
  output logic [WIDTH_W-1:0] width_o,
  output logic               width_valid_o
);

  // The posedge capture flop counts as the first of the SYNC_STAGES.
  localparam int PAIR_STAGES = SYNC_STAGES - 1;
  localparam int CNT_W       = filt_cnt_w(GLITCH_CYCLES);

  logic                        rise0_q;
  logic                        fall0_q;
  logic [PAIR_STAGES-1:0][1:0] pair_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || !en_i) begin
      rise0_q <= 1'b0;
    end else begin
      rise0_q <= data_i;
    end
  end

  // Reset and enable are only ever changed away from the falling edge, so this
  // flop sees the same values the preceding posedge did.
  always_ff @(negedge clk_i) begin
    if (!reset_n_i || !en_i) begin
      fall0_q <= 1'b0;
    end else begin
      fall0_q <= data_i;
    end
  end

  // NOTE: the shift chain is a flop array, not a RAM, so clearing every entry
  // on reset is cheap and guarantees d_in never shows stale pin data.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || !en_i) begin
      pair_q <= '0;
    end else begin
      pair_q[0] <= {fall0_q, rise0_q};
      for (int s = 1; s < PAIR_STAGES; s++) begin
        pair_q[s] <= pair_q[s-1];
      end
    end
  end

  assign pair_o = pair_q[PAIR_STAGES-1];

  logic [SYNC_STAGES-1:0] env_sync_q;
  logic                   env_s;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      env_sync_q <= '0;
    end else begin
      env_sync_q <= {env_sync_q[SYNC_STAGES-2:0], env_i};
    end
  end

  assign env_s = env_sync_q[SYNC_STAGES-1];

  logic             e_q, e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    e_d   = e_q;
    cnt_d = '0;
    if (GLITCH_CYCLES == 0) begin
      e_d = env_s;
    end else if (env_s != e_q) begin
      if (cnt_q == CNT_W'(GLITCH_CYCLES - 1)) begin
        e_d = env_s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (!en_i) begin
      e_d   = 1'b0;
      cnt_d = '0;
    end
    // Forced clears on disable must not look like a falling envelope.
    rise_d = en_i &  e_d & ~e_q;
    fall_d = en_i & ~e_d &  e_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      e_q    <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign status_o = '{e_in: e_q, e_rise: rise_q, e_fall: fall_q};

`ifdef INOUT_FACE_WIDTH_COUNTER_EN
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               wvalid_q, wvalid_d;

  always_comb begin
    wcnt_d   = wcnt_q;
    width_d  = width_q;
    wvalid_d = 1'b0;
    if (rise_d) begin
      wcnt_d = WIDTH_W'(1);
    end else if (e_q && e_d && wcnt_q != WIDTH_MAX) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    // The count covers cycles already spent high, so the fall reports it as is.
    if (fall_d) begin
      width_d  = wcnt_q;
      wvalid_d = 1'b1;
    end
    if (!en_i) begin
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wcnt_q   <= '0;
      width_q  <= '0;
      wvalid_q <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      width_q  <= width_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign width_o       = width_q;
  assign width_valid_o = wvalid_q;
`else
  assign width_o       = '0;
  assign width_valid_o = 1'b0;
`endif

endmodule

// File: rtl/inout_face_manager_multi.sv
// Photodiode face front end: CHANNELS independent inout_face_channel instances
// packed onto flat buses. Width outputs are live only with INOUT_FACE_WIDTH_COUNTER_EN.
module inout_face_manager_multi
  import inout_face_manager_multi_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = MIN_SYNC_STAGES,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int WIDTH_W       = DEF_WIDTH_W
) (
  input  logic                        clk_96MHz,
  input  logic                        reset_n,
  input  logic [CHANNELS-1:0]         data_wire,
  input  logic [CHANNELS-1:0]         envelop_wire,
  input  logic [CHANNELS-1:0]         channel_en,
  output logic [2*CHANNELS-1:0]       d_in,
  output logic [CHANNELS-1:0]         e_in,
  output logic [CHANNELS-1:0]         e_rise,
  output logic [CHANNELS-1:0]         e_fall,
  output logic [CHANNELS*WIDTH_W-1:0] e_width,
  output logic [CHANNELS-1:0]         e_width_valid
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    env_status_t status;

    inout_face_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .GLITCH_CYCLES(GLITCH_CYCLES),
      .WIDTH_W      (WIDTH_W)
    ) u_channel (
      .clk_i        (clk_96MHz),
      .reset_n_i    (reset_n),
      .data_i       (data_wire[i]),
      .env_i        (envelop_wire[i]),
      .en_i         (channel_en[i]),
      .pair_o       (d_in[2*i +: 2]),
      .status_o     (status),
      .width_o      (e_width[i*WIDTH_W +: WIDTH_W]),
      .width_valid_o(e_width_valid[i])
    );

    assign e_in[i]   = status.e_in;
    assign e_rise[i] = status.e_rise;
    assign e_fall[i] = status.e_fall;
  end

endmodule

// File: tb/tb_inout_face_manager_multi.sv
// Randomised scoreboard bench for inout_face_manager_multi (default parameters plus a
// WIDTH_W=4 copy for saturation); expectations follow INOUT_FACE_WIDTH_COUNTER_EN.
module tb_inout_face_manager_multi;

  localparam int CH   = 3;
  localparam int S    = 2;
  localparam int G    = 4;
  localparam int W    = 16;
  localparam int W4   = 4;
  localparam int NCYC = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [CH-1:0]     data_wire, envelop_wire, channel_en;
  logic [2*CH-1:0]   d_in, d_in4;
  logic [CH-1:0]     e_in, e_rise, e_fall, e_valid;
  logic [CH-1:0]     e_in4, e_rise4, e_fall4, e_valid4;
  logic [CH*W-1:0]   e_width;
  logic [CH*W4-1:0]  e_width4;

  inout_face_manager_multi #(.CHANNELS(CH), .SYNC_STAGES(S), .GLITCH_CYCLES(G), .WIDTH_W(W)) dut (
    .clk_96MHz(clk), .reset_n(reset_n), .data_wire(data_wire), .envelop_wire(envelop_wire),
    .channel_en(channel_en), .d_in(d_in), .e_in(e_in), .e_rise(e_rise), .e_fall(e_fall),
    .e_width(e_width), .e_width_valid(e_valid));

  inout_face_manager_multi #(.CHANNELS(CH), .SYNC_STAGES(S), .GLITCH_CYCLES(G), .WIDTH_W(W4)) dut4 (
    .clk_96MHz(clk), .reset_n(reset_n), .data_wire(data_wire), .envelop_wire(envelop_wire),
    .channel_en(channel_en), .d_in(d_in4), .e_in(e_in4), .e_rise(e_rise4), .e_fall(e_fall4),
    .e_width(e_width4), .e_width_valid(e_valid4));

  // Per-cycle stimulus: value at posedge k, value for the following negedge, etc.
  logic [CH-1:0] rise_h [NCYC];
  logic [CH-1:0] fall_h [NCYC];
  logic [CH-1:0] env_h  [NCYC];
  logic [CH-1:0] en_h   [NCYC];
  logic          rst_h  [NCYC];

  typedef struct {
    int              k;
    logic [2*CH-1:0] d;
    logic [CH-1:0]   e, r, f, v, v4;
    logic [CH*W-1:0] w;
    logic [CH*W4-1:0] w4;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s after edge %0d: got %h, expected %h", nm, k, act, req);
    end
  endtask

  // Synchronised envelope as seen by the filter at edge k: the pin value from S
  // edges earlier, unless a reset wiped the chain in between.
  function automatic logic env_s(input int ch, input int k);
    if (k - S < 0) return 1'b0;
    for (int j = k - S; j < k; j++) if (!rst_h[j]) return 1'b0;
    return env_h[k-S][ch];
  endfunction

  function automatic logic [1:0] pair_at(input int ch, input int k);
    int j;
    j = k - S + 1;
    if (j < 0) return 2'b00;
    for (int m = j; m <= k; m++) if (!rst_h[m] || !en_h[m][ch]) return 2'b00;
    return {fall_h[j][ch], rise_h[j][ch]};
  endfunction

  task automatic set_env(input int ch, input int start, input int len, input logic val);
    for (int t = start; t < start + len && t < NCYC; t++) env_h[t][ch] = val;
  endtask

  // Monitor: pops one expectation per posedge once the stimulus has issued one.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check("d_in",           x.k, 64'(d_in),     64'(x.d));
        check("e_in",           x.k, 64'(e_in),     64'(x.e));
        check("e_rise",         x.k, 64'(e_rise),   64'(x.r));
        check("e_fall",         x.k, 64'(e_fall),   64'(x.f));
        check("e_width",        x.k, 64'(e_width),  64'(x.w));
        check("e_width_valid",  x.k, 64'(e_valid),  64'(x.v));
        check("e_width_w4",     x.k, 64'(e_width4), 64'(x.w4));
        check("e_width_valid4", x.k, 64'(e_valid4), 64'(x.v4));
      end
    end
  end

  initial begin
    logic [CH-1:0]    e_m;
    int               restart [CH];
    int               rise_at [CH];
    logic [CH*W-1:0]  w_m;
    logic [CH*W4-1:0] w4_m;
    exp_t             x;
    logic             toggle;
    int               len;

    for (int k = 0; k < NCYC; k++) begin
      rst_h[k]  = (k >= 5) && !(k >= 800 && k < 803);
      en_h[k]   = '1;
      rise_h[k] = CH'($urandom);
      fall_h[k] = CH'($urandom);
      env_h[k]  = (k < 5) ? CH'($urandom) : '0;
    end
    // Lone negedge-only pulse on channel 0 data.
    for (int k = 8; k < 15; k++) begin
      rise_h[k][0] = 1'b0;
      fall_h[k][0] = (k == 11);
    end
    set_env(0, 20, 3, 1'b1);
    set_env(0, 30, 4, 1'b1);
    set_env(2, 50, 100, 1'b1);
    set_env(0, 200, 40, 1'b1);
    set_env(1, 200, 40, 1'b1);
    for (int k = 220; k < 225; k++) en_h[k][1] = 1'b0;
    set_env(2, 260, 40, 1'b1);
    for (int ch = 0; ch < CH; ch++) begin
      int   t;
      logic v;
      t = 320;
      v = 1'b0;
      while (t < NCYC - 30) begin
        len = int'($urandom_range(1, 25));
        set_env(ch, t, (t + len > NCYC - 30) ? NCYC - 30 - t : len, v);
        v = ~v;
        t += len;
      end
      for (int k = 320; k < NCYC - 30; k++) if ($urandom_range(0, 63) == 0) en_h[k][ch] = 1'b0;
    end

    e_m  = '0;
    w_m  = '0;
    w4_m = '0;
    for (int i = 0; i < CH; i++) begin
      restart[i] = -1;
      rise_at[i] = 0;
    end

    reset_n = 1'b0;
    data_wire = '0;
    envelop_wire = '0;
    channel_en = '0;

    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      #1;
      reset_n      = rst_h[k];
      data_wire    = rise_h[k];
      envelop_wire = env_h[k];
      channel_en   = en_h[k];

      x.k = k;
      x.r = '0;
      x.f = '0;
      x.v = '0;
      for (int i = 0; i < CH; i++) begin
        x.d[2*i +: 2] = pair_at(i, k);
        if (!rst_h[k]) begin
          e_m[i] = 1'b0;
          restart[i] = k;
          w_m[i*W +: W] = '0;
          w4_m[i*W4 +: W4] = '0;
        end else if (!en_h[k][i]) begin
          e_m[i] = 1'b0;
          restart[i] = k;
        end else begin
          // Toggle once the last G filter samples, all after the latest restart, disagree.
          toggle = (k - G + 1 > restart[i]);
          for (int j = k - G + 1; j <= k; j++) if (toggle && env_s(i, j) == e_m[i]) toggle = 1'b0;
          if (toggle) begin
            e_m[i] = ~e_m[i];
            restart[i] = k;
            if (e_m[i]) begin
              x.r[i] = 1'b1;
              rise_at[i] = k;
            end else begin
              x.f[i] = 1'b1;
              len = k - rise_at[i];
              w_m[i*W +: W]    = W'((len > (1 << W) - 1) ? (1 << W) - 1 : len);
              w4_m[i*W4 +: W4] = W4'((len > (1 << W4) - 1) ? (1 << W4) - 1 : len);
              x.v[i] = 1'b1;
            end
          end
        end
      end
      x.e = e_m;
`ifdef INOUT_FACE_WIDTH_COUNTER_EN
      x.w  = w_m;
      x.w4 = w4_m;
      x.v4 = x.v;
`else
      x.w  = '0;
      x.w4 = '0;
      x.v  = '0;
      x.v4 = '0;
`endif
      sb_q.push_back(x);

      @(posedge clk);
      #1;
      data_wire = fall_h[k];
    end

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drained", NCYC, 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
